// File: rtl/dual_fast_spi_pkg.sv
// Shared definitions for the dual-lane SPI transmitter and its receiver.
// Holds the FSM state encoding, the default word width and the pair-counter width.
// Pure definitions: no latency, no backpressure.
package dual_fast_spi_pkg;

    localparam int NB_BIT_DEF = 32;

    function automatic int pair_w(input int nb);
        return (nb > 2) ? $clog2(nb / 2) : 1;
    endfunction

    localparam int PAIR_W = pair_w(NB_BIT_DEF);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        FLUSH_LO,
        FLUSH_HI,
        FLUSH_END,
        GAP
    } spi_state_t;

endpackage

// File: rtl/dual_fast_spi_tx_clk_div.sv
// Phase timer for the SPI transmitter: tick on the last cycle of each CLK_DIV-long phase.
// Latency: tick is asserted CLK_DIV-1 cycles after run rises; pre_tick fires one cycle earlier.
// Backpressure: none; the counter is held at zero while run is low.
module spi_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic synth_clk,
    input  logic rst_n,
    input  logic run,
    output logic tick,
    output logic pre_tick
);

    logic [7:0] cnt;

    always_ff @(posedge synth_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    assign tick     = run && (cnt == 8'(CLK_DIV - 1));
    // pre_tick has no meaning when every cycle is a terminal cycle
    assign pre_tick = run && (CLK_DIV > 1) && (cnt == 8'(CLK_DIV - 2));

endmodule

// File: rtl/dual_fast_spi_tx.sv
// Dual-lane SPI transmitter: shifts NB_BIT-bit words MSB first, two bits per sck period.
// Latency: cs falls on the accepting edge; CLK_DIV*(NB_BIT+1) cycles of cs low per word.
// Backpressure: tx_ready only in IDLE and in the last cycle of a word (burst without cs gap).
module dual_fast_spi_tx
    import dual_fast_spi_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int NB_BIT  = NB_BIT_DEF,
    parameter int CS_GAP  = 2
) (
    input  logic              synth_clk,
    input  logic              rst_n,
    input  logic [NB_BIT-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              sck_out,
    output logic              cs_out,
    output logic              mosi1_out,
    output logic              mosi0_out,
    output logic              busy
);

    localparam int NPAIR = NB_BIT / 2;
    localparam int PW    = pair_w(NB_BIT);
    localparam int GW    = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    spi_state_t        state, state_nxt;
    logic [NB_BIT-1:0] shreg, shreg_nxt;
    logic [PW-1:0]     pair_cnt, pair_nxt;
    logic [GW-1:0]     gap_cnt, gap_nxt;
    logic              run, tick, pre_tick, xfer, last_pair, rdy_nxt;

    assign run       = state inside {SETUP, HIGH, LOW, FLUSH_LO, FLUSH_HI, FLUSH_END};
    assign xfer      = tx_valid && tx_ready;
    assign last_pair = (pair_cnt == PW'(NPAIR - 1));

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .synth_clk (synth_clk),
        .rst_n     (rst_n),
        .run       (run),
        .tick      (tick),
        .pre_tick  (pre_tick)
    );

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        pair_nxt  = pair_cnt;
        gap_nxt   = gap_cnt;
        case (state)
            IDLE: begin
                if (xfer) begin
                    shreg_nxt = tx_data;
                    pair_nxt  = '0;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (tick) state_nxt = HIGH;
            end
            HIGH: begin
                if (tick) begin
                    state_nxt = LOW;
                    // the final pair stays on the wire through the last LOW phase
                    if (!last_pair) shreg_nxt = shreg << 2;
                end
            end
            LOW: begin
                if (tick) begin
                    if (!last_pair) begin
                        pair_nxt  = pair_cnt + PW'(1);
                        state_nxt = HIGH;
                    end else if (xfer) begin
                        shreg_nxt = tx_data;
                        pair_nxt  = '0;
                        state_nxt = SETUP;
                    end else begin
                        shreg_nxt = '0;
                        state_nxt = FLUSH_LO;
                    end
                end
            end
            FLUSH_LO: begin
                if (tick) state_nxt = FLUSH_HI;
            end
            FLUSH_HI: begin
                if (tick) state_nxt = FLUSH_END;
            end
            FLUSH_END: begin
                if (tick) begin
                    gap_nxt   = '0;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GW'(CS_GAP - 1)) begin
                    gap_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap_cnt + GW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // ready is registered, so it is raised one cycle ahead of the final LOW cycle
        rdy_nxt = (state_nxt == IDLE)
               || (state == LOW  && last_pair && !tick && pre_tick)
               || (state == HIGH && last_pair && tick && CLK_DIV == 1);
    end

    always_ff @(posedge synth_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            pair_cnt <= '0;
            gap_cnt  <= '0;
            tx_ready <= 1'b0;
            sck_out  <= 1'b0;
            cs_out   <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            pair_cnt <= pair_nxt;
            gap_cnt  <= gap_nxt;
            tx_ready <= rdy_nxt;
            sck_out  <= (state_nxt == HIGH) || (state_nxt == FLUSH_HI);
            cs_out   <= !(state_nxt inside {SETUP, HIGH, LOW});
            busy     <= (state_nxt != IDLE);
        end
    end

    // shreg is cleared whenever cs is high, which keeps both lanes at zero there
    assign mosi1_out = shreg[NB_BIT-1];
    assign mosi0_out = shreg[NB_BIT-2];

endmodule

// File: tb/tb_dual_fast_spi_tx.sv
// Bench for dual_fast_spi_tx: instances at CLK_DIV 2, 1 and 255 with line monitors,
// plus a behavioural receiver with an output queue looped back on the CLK_DIV=1 instance.
module tb_dual_fast_spi_tx;

    logic        synth_clk;
    logic        rst_n;
    logic [31:0] tx_data  [3];
    logic        tx_valid [3];
    logic        tx_ready [3];
    logic        sck_o    [3];
    logic        cs_o     [3];
    logic        m1       [3];
    logic        m0       [3];
    logic        busy     [3];

    int n_chk = 0;
    int n_err = 0;

    function automatic int div_of(input int i);
        return (i == 0) ? 2 : (i == 1) ? 1 : 255;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dual_fast_spi_tx #(
            .CLK_DIV ((g == 0) ? 2 : (g == 1) ? 1 : 255),
            .NB_BIT  (32),
            .CS_GAP  (2)
        ) u_dut (
            .synth_clk (synth_clk),
            .rst_n     (rst_n),
            .tx_data   (tx_data[g]),
            .tx_valid  (tx_valid[g]),
            .tx_ready  (tx_ready[g]),
            .sck_out   (sck_o[g]),
            .cs_out    (cs_o[g]),
            .mosi1_out (m1[g]),
            .mosi0_out (m0[g]),
            .busy      (busy[g])
        );
    end

    initial synth_clk = 1'b0;
    always #5 synth_clk = ~synth_clk;

    // line monitor, sampled on the falling clock edge
    int          cyc = 0;
    int          rise_cnt [3], flush_cnt [3], cs_len [3], cs_run [3];
    int          hi_run [3], lo_run [3], viol [3], wpos [3];
    int          cs_rise_cyc [3], rdy_rise_cyc [3];
    logic [31:0] obs_word [3];
    bit          prv_sck [3], prv_cs [3], prv_rdy [3];
    bit   [1:0]  prv_m [3];
    logic [31:0] mon_q [$];

    always @(negedge synth_clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            prv_sck[i] <= sck_o[i];
            prv_cs[i]  <= cs_o[i];
            prv_rdy[i] <= tx_ready[i];
            prv_m[i]   <= {m1[i], m0[i]};
            if (!cs_o[i]) cs_run[i] <= cs_run[i] + 1;
            if (cs_o[i] && !prv_cs[i]) begin
                cs_len[i]      <= cs_run[i];
                cs_run[i]      <= 0;
                cs_rise_cyc[i] <= cyc;
                wpos[i]        <= 0;
            end
            if (tx_ready[i] && !prv_rdy[i]) rdy_rise_cyc[i] <= cyc;
            if (cs_o[i] && (m1[i] || m0[i])) viol[i] <= viol[i] + 1;
            if (sck_o[i] && !prv_sck[i]) begin
                if ({m1[i], m0[i]} != prv_m[i]) viol[i] <= viol[i] + 1;
                if (cs_o[i]) begin
                    flush_cnt[i] <= flush_cnt[i] + 1;
                end else begin
                    rise_cnt[i] <= rise_cnt[i] + 1;
                    wpos[i]     <= (wpos[i] == 15) ? 0 : wpos[i] + 1;
                    obs_word[i] <= {obs_word[i][29:0], m1[i], m0[i]};
                    if (wpos[i] != 0 && lo_run[i] != div_of(i)) viol[i] <= viol[i] + 1;
                    if (i == 0 && wpos[i] == 15) mon_q.push_back({obs_word[i][29:0], m1[i], m0[i]});
                end
                lo_run[i] <= 0;
                hi_run[i] <= 1;
            end else if (!sck_o[i] && prv_sck[i]) begin
                if (hi_run[i] != div_of(i)) viol[i] <= viol[i] + 1;
                hi_run[i] <= 0;
                lo_run[i] <= 1;
            end else if (sck_o[i]) begin
                hi_run[i] <= hi_run[i] + 1;
            end else begin
                lo_run[i] <= lo_run[i] + 1;
            end
        end
    end

    int xfer_cnt [3], xfer_cyc [3], xfer_prev [3];

    always @(posedge synth_clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_n && tx_valid[i] && tx_ready[i]) begin
                xfer_cnt[i]  <= xfer_cnt[i] + 1;
                xfer_prev[i] <= xfer_cyc[i];
                xfer_cyc[i]  <= cyc;
            end
        end
    end

    // receiver: a full word commits on the next rising sck (flush or next word)
    logic [31:0] rx_sh, rx_word;
    int          rx_n = 0;
    bit          rx_pend = 1'b0;
    logic [31:0] rx_q [$];

    always @(posedge sck_o[1] or posedge cs_o[1]) begin
        if (sck_o[1]) begin
            if (rx_pend) rx_q.push_back(rx_word);
            if (!cs_o[1]) begin
                rx_sh <= {rx_sh[29:0], m1[1], m0[1]};
                if (rx_n == 15) begin
                    rx_word <= {rx_sh[29:0], m1[1], m0[1]};
                    rx_pend <= 1'b1;
                    rx_n    <= 0;
                end else begin
                    rx_n    <= rx_n + 1;
                    rx_pend <= 1'b0;
                end
            end else begin
                rx_pend <= 1'b0;
            end
        end else begin
            rx_n <= 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int i, input logic [31:0] d);
        int t;
        t = 0;
        tx_data[i]  = d;
        tx_valid[i] = 1'b1;
        while (tx_ready[i] !== 1'b1 && t < 20000) begin
            @(negedge synth_clk);
            t++;
        end
        if (t >= 20000) chk("send_ready_timeout", 64'(tx_ready[i]), 64'd1);
        @(negedge synth_clk);
        tx_valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i, input int lim);
        int t;
        t = 0;
        repeat (2) @(negedge synth_clk);
        while (busy[i] && t < lim) begin
            @(negedge synth_clk);
            t++;
        end
        if (t >= lim) chk("idle_timeout", 64'(busy[i]), 64'd0);
        repeat (3) @(negedge synth_clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          b_r, b_f, b_x, qb, rb;
    logic [31:0] w;
    logic [31:0] exp_q [$];

    initial begin
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tx_valid[i] = 1'b0;
            tx_data[i]  = '0;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(negedge synth_clk);

        chk("rst_cs",    64'(cs_o[0]), 64'd1);
        chk("rst_sck",   64'(sck_o[0]), 64'd0);
        chk("rst_mosi",  64'({m1[0], m0[0]}), 64'd0);
        chk("rst_ready", 64'(tx_ready[0]), 64'd0);
        chk("rst_busy",  64'(busy[0]), 64'd0);
        rst_n = 1'b1;
        @(posedge synth_clk);
        #1;
        chk("ready_first_edge", 64'(tx_ready[0]), 64'd1);
        @(negedge synth_clk);

        // single word at CLK_DIV=2
        b_r = rise_cnt[0]; b_f = flush_cnt[0];
        send(0, 32'hA5A5_0F0F);
        wait_idle(0, 500);
        chk("w1_first_pairs", 64'(obs_word[0][31:24]), 64'b10_10_01_01);
        chk("w1_word",        64'(obs_word[0]), 64'hA5A5_0F0F);
        chk("w1_rises",       64'(rise_cnt[0] - b_r), 64'd16);
        chk("w1_cs_len",      64'(cs_len[0]), 64'd66);
        chk("w1_flush",       64'(flush_cnt[0] - b_f), 64'd1);
        chk("w1_ready_back",  64'(rdy_rise_cyc[0] - cs_rise_cyc[0]), 64'd8);

        // back-to-back burst
        b_r = rise_cnt[0]; b_f = flush_cnt[0]; qb = mon_q.size();
        send(0, 32'h0000_0001);
        send(0, 32'h8000_0000);
        wait_idle(0, 800);
        chk("bb_cs_len", 64'(cs_len[0]), 64'd132);
        chk("bb_rises",  64'(rise_cnt[0] - b_r), 64'd32);
        chk("bb_flush",  64'(flush_cnt[0] - b_f), 64'd1);
        chk("bb_gap",    64'(xfer_cyc[0] - xfer_prev[0]), 64'd66);
        chk("bb_nwords", 64'(mon_q.size() - qb), 64'd2);
        chk("bb_word0",  (mon_q.size() > qb)     ? 64'(mon_q[qb])     : 64'hx, 64'h0000_0001);
        chk("bb_word1",  (mon_q.size() > qb + 1) ? 64'(mon_q[qb + 1]) : 64'hx, 64'h8000_0000);

        // tx_valid held with junk data while the word is in flight
        b_x = xfer_cnt[0]; qb = mon_q.size();
        send(0, 32'h1234_5678);
        tx_data[0] = 32'hDEAD_BEEF; tx_valid[0] = 1'b1;
        for (int t = 0; t < 200 && tx_ready[0] !== 1'b1; t++) @(negedge synth_clk);
        chk("hold_no_extra_load", 64'(xfer_cnt[0] - b_x), 64'd1);
        tx_data[0] = 32'hCAFE_F00D;
        @(negedge synth_clk);
        tx_valid[0] = 1'b0;
        wait_idle(0, 800);
        repeat (20) @(negedge synth_clk);
        chk("hold_loads",  64'(xfer_cnt[0] - b_x), 64'd2);
        chk("hold_gap",    64'(xfer_cyc[0] - xfer_prev[0]), 64'd66);
        chk("hold_word0",  (mon_q.size() > qb)     ? 64'(mon_q[qb])     : 64'hx, 64'h1234_5678);
        chk("hold_word1",  (mon_q.size() > qb + 1) ? 64'(mon_q[qb + 1]) : 64'hx, 64'hCAFE_F00D);
        chk("div2_glitch", 64'(viol[0]), 64'd0);

        // CLK_DIV=255
        b_r = rise_cnt[2]; b_f = flush_cnt[2];
        send(2, 32'h3C96_A55A);
        wait_idle(2, 12000);
        chk("d255_word",       64'(obs_word[2]), 64'h3C96_A55A);
        chk("d255_cs_len",     64'(cs_len[2]), 64'd8415);
        chk("d255_rises",      64'(rise_cnt[2] - b_r), 64'd16);
        chk("d255_flush",      64'(flush_cnt[2] - b_f), 64'd1);
        chk("d255_ready_back", 64'(rdy_rise_cyc[2] - cs_rise_cyc[2]), 64'd767);
        chk("d255_glitch",     64'(viol[2]), 64'd0);

        // loopback at CLK_DIV=1, mixed bursts and idle gaps
        rb = rx_q.size();
        for (int k = 0; k < 100; k++) begin
            w = $urandom;
            exp_q.push_back(w);
            send(1, w);
            if ($urandom_range(0, 3) == 0) begin
                wait_idle(1, 200);
                repeat ($urandom_range(0, 4)) @(negedge synth_clk);
            end
        end
        wait_idle(1, 500);
        chk("lb_count", 64'(rx_q.size() - rb), 64'd100);
        for (int k = 0; k < 100; k++)
            chk("lb_word", (rx_q.size() > rb + k) ? 64'(rx_q[rb + k]) : 64'hx, 64'(exp_q[k]));
        chk("div1_glitch", 64'(viol[1]), 64'd0);

        // reset in the middle of a word
        rb = rx_q.size(); b_r = rise_cnt[1];
        send(1, 32'h1122_3344);
        for (int t = 0; t < 200 && (rise_cnt[1] - b_r) < 7; t++) @(negedge synth_clk);
        chk("abort_reached_pair7", 64'((rise_cnt[1] - b_r) >= 7), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cs",   64'(cs_o[1]), 64'd1);
        chk("abort_sck",  64'(sck_o[1]), 64'd0);
        chk("abort_busy", 64'(busy[1]), 64'd0);
        repeat (2) @(negedge synth_clk);
        rst_n = 1'b1;
        repeat (10) @(negedge synth_clk);
        chk("abort_rx_empty", 64'(rx_q.size() - rb), 64'd0);
        send(1, 32'h5A5A_C3C3);
        wait_idle(1, 500);
        chk("after_abort_count", 64'(rx_q.size() - rb), 64'd1);
        chk("after_abort_word",  (rx_q.size() > rb) ? 64'(rx_q[rb]) : 64'hx, 64'h5A5A_C3C3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
